// File: rtl/stream_mux_rr.sv
// stream_mux_rr: packet-locked N-channel stream mux, fixed or round-robin select, registered output.
// The selection is held for a whole in_last-delimited packet; the output register drains and reloads in one cycle.
module stream_mux_rr #(
  parameter int NCH = 16,
  parameter int DW  = 8,
  parameter int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_last,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [SW-1:0]     grant,
  output logic              busy
);
  logic [SW-1:0] ptr_q, ptr_d, lock_q, lock_d, grant_q, grant_d, rr_c, c, idx;
  logic          rr_hit, ok, load_en, xfer;
  logic          out_valid_q, out_valid_d, out_last_q, out_last_d, busy_q, busy_d;
  logic [DW-1:0] out_data_q, out_data_d;
  // Scan from farthest to nearest so the first valid channel after ptr wins.
  always_comb begin
    rr_c = '0;
    rr_hit = 1'b0;
    idx = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = ptr_q + SW'(i);
      if (in_valid[idx]) begin
        rr_c = idx;
        rr_hit = 1'b1;
      end
    end
  end
  assign load_en  = !out_valid_q || out_ready;
  assign c        = busy_q ? lock_q : (mode ? rr_c : sel);
  assign ok       = rst_n && load_en && (busy_q || !mode || rr_hit);
  assign in_ready = {{(NCH-1){1'b0}}, ok} << c;
  assign xfer     = in_valid[c] && in_ready[c];
  always_comb begin
    out_valid_d = xfer ? 1'b1 : (load_en ? 1'b0 : out_valid_q);
    out_data_d  = xfer ? in_data[c*DW +: DW] : out_data_q;
    out_last_d  = xfer ? in_last[c] : out_last_q;
    grant_d     = xfer ? c : grant_q;
    busy_d      = xfer ? !in_last[c] : busy_q;
    lock_d      = xfer ? c : lock_q;
    ptr_d       = (xfer && in_last[c]) ? c : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      lock_q      <= '0;
      ptr_q       <= SW'(NCH-1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      lock_q      <= lock_d;
      ptr_q       <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed scenarios plus random traffic against a cycle-level reference model.
module tb_stream_mux_rr;
  localparam int NCH = 16, DW = 8, SW = 4;
  logic              clk = 1'b0, rst_n = 1'b0, mode = 1'b0, out_ready = 1'b1;
  logic [SW-1:0]     sel = '0;
  logic [NCH-1:0]    in_valid = '0, in_last = '0, in_ready, last_ready;
  logic [NCH*DW-1:0] in_data = '0;
  logic              out_valid, out_last, busy;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     grant;
  int n_tests = 0, n_fail = 0;
  int m_ov, m_od, m_ol, m_g, m_busy, m_lock, m_ptr;
  stream_mux_rr #(.NCH(NCH), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .grant(grant), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Channel the model would serve this cycle, or -1 when round-robin finds nothing.
  function automatic int pick();
    if (m_busy != 0) return m_lock;
    if (!mode) return int'(sel);
    for (int k = 1; k <= NCH; k++)
      if (in_valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
    return -1;
  endfunction
  task automatic tick();
    int c;
    bit ld, xf;
    logic [NCH-1:0] er;
    @(negedge clk);
    c = pick();
    ld = (m_ov == 0) || out_ready;
    er = (rst_n && ld && c >= 0) ? (16'h1 << c) : '0;
    last_ready = in_ready;
    check("in_ready", in_ready, er);
    xf = 0;
    if (er != 0) xf = in_valid[c];
    if (!rst_n) begin
      m_ov = 0; m_od = 0; m_ol = 0; m_g = 0; m_busy = 0; m_lock = 0; m_ptr = NCH - 1;
    end else if (xf) begin
      m_ov = 1; m_od = in_data[c*DW +: DW]; m_ol = in_last[c]; m_g = c; m_busy = !in_last[c];
      if (in_last[c]) m_ptr = c;
      else m_lock = c;
    end else if (ld) m_ov = 0;
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_ov);
    check("out_data", out_data, m_od);
    check("out_last", out_last, m_ol);
    check("grant", grant, m_g);
    check("busy", busy, m_busy);
  endtask
  task automatic set_ch(input int k, input bit v, input logic [7:0] d, input bit l);
    in_valid[k] = v;
    in_data[k*DW +: DW] = d;
    in_last[k] = l;
  endtask
  initial begin
    tick(); tick();
    check("rst_ov", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    rst_n = 1; mode = 0; sel = 5; set_ch(5, 1, 8'hA1, 1);
    tick();
    check("t1_rdy", last_ready, 16'h0020);
    check("t1_data", out_data, 8'hA1);
    check("t1_grant", grant, 5);
    check("t1_last", out_last, 1);
    in_valid = '0; tick();
    rst_n = 0; tick();
    rst_n = 1; mode = 1;
    for (int k = 0; k < NCH; k++) set_ch(k, 1, 8'(k), 1);
    for (int j = 0; j < 17; j++) begin
      tick();
      check("t2_seq", out_data, j % 16);
      check("t2_ov", out_valid, 1);
    end
    in_valid = '0; in_last = '0; tick();
    set_ch(3, 1, 8'h31, 0); set_ch(7, 1, 8'h70, 1);
    tick(); check("t3_g1", grant, 3); check("t3_b1", busy, 1);
    set_ch(3, 1, 8'h32, 0);
    tick(); check("t3_g2", grant, 3); check("t3_b2", busy, 1);
    set_ch(3, 1, 8'h33, 1);
    tick(); check("t3_g3", grant, 3); check("t3_b3", busy, 0); check("t3_d3", out_data, 8'h33);
    in_valid[3] = 0;
    tick(); check("t3_g4", grant, 7); check("t3_d4", out_data, 8'h70);
    in_valid = '0; tick();
    mode = 0; sel = 2;
    set_ch(2, 1, 8'h21, 0); tick(); check("t4_g1", grant, 2);
    set_ch(2, 1, 8'h22, 0); tick();
    sel = 9; set_ch(9, 1, 8'h90, 1);
    set_ch(2, 1, 8'h23, 0); tick();
    check("t4_g3", grant, 2); check("t4_rdy9", last_ready[9], 0);
    set_ch(2, 1, 8'h24, 1); tick(); check("t4_g4", grant, 2); check("t4_d4", out_data, 8'h24);
    in_valid[2] = 0;
    tick(); check("t4_g5", grant, 9); check("t4_d5", out_data, 8'h90);
    in_valid = '0; tick();
    sel = 1; set_ch(1, 1, 8'h51, 1); tick();
    out_ready = 0; set_ch(1, 1, 8'h52, 1);
    for (int j = 0; j < 4; j++) begin
      tick();
      check("t5_hold", out_data, 8'h51);
      check("t5_grant", grant, 1);
      check("t5_rdy", last_ready, 0);
    end
    out_ready = 1;
    tick(); check("t5_rdy_go", last_ready, 16'h0002); check("t5_next", out_data, 8'h52);
    in_valid = '0; tick();
    mode = 1; set_ch(4, 1, 8'h41, 0);
    tick(); check("t6_g", grant, 4); check("t6_busy", busy, 1);
    rst_n = 0;
    tick(); check("t6_rdy", last_ready, 0); check("t6_ov", out_valid, 0); check("t6_busy0", busy, 0);
    rst_n = 1; set_ch(0, 1, 8'h01, 1); set_ch(4, 1, 8'h42, 1);
    tick(); check("t6_g0", grant, 0); check("t6_d0", out_data, 8'h01);
    for (int j = 0; j < 800; j++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel = SW'($urandom);
      in_valid = NCH'($urandom & $urandom);
      in_last = NCH'($urandom & $urandom);
      in_data = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-channel stream multiplexer. It is the registered, handshaked successor to the gate-level 16:1 mux.
- Selects one of NCH input streams, by external select or by packet-level round-robin arbitration.
- Holds the selection for a whole packet (in_last-delimited).
- Presents the chosen word on a single registered output port with valid/ready flow control.
- Sits between multiple producer blocks and one shared consumer (datapath or serialiser).

Parameters:
NCH, 16, number of input channels (power of two, >=2)
DW, 8, data width per channel in bits
SW, $clog2(NCH), select/grant width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration
sel  input  SW  channel select used when mode=0
in_valid  input  NCH  per-channel word valid
in_data  input  NCH*DW  channel k occupies bits [k*DW +: DW]
in_last  input  NCH  per-channel end-of-packet flag
in_ready  output  NCH  per-channel accept (combinational)
out_valid  output  1  output register holds a word
out_data  output  DW  registered output word
out_last  output  1  registered end-of-packet flag
out_ready  input  1  consumer accepts output word
grant  output  SW  channel index of the word currently in the output register
busy  output  1  packet in progress (lock held)

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_data=0, out_last=0, grant=0, busy=0, RR pointer ptr=NCH-1, lock channel=0.
- While rst_n=0, in_ready is forced all-zero.
- load_en = !out_valid || out_ready. The output register accepts a new word in the same cycle the old one drains.
- Chosen channel c:
  - busy=1: c = lock channel.
  - busy=0, mode=0: c = sel.
  - busy=0, mode=1: first k with in_valid[k]=1, searching cyclically from ptr+1 (ptr+1, ptr+2, ..., wrap modulo NCH). If none is valid, no transfer occurs.
- in_ready[c] = load_en. All other in_ready bits are 0; at most one bit is ever high.
- Transfer = in_valid[c] && in_ready[c]. On a transfer clock edge:
  - out_data <= in_data[c], out_last <= in_last[c], out_valid <= 1, grant <= c.
- If load_en=1 and there is no transfer, out_valid <= 0. out_data, out_last and grant hold their values.
- If load_en=0, the output register holds all fields.
- Latency: input word appears on out_* one cycle after transfer. Throughput: one word per cycle when out_ready is held at 1.
- Lock:
  - Transfer with in_last=0 sets busy<=1 and lock channel<=c.
  - Transfer with in_last=1 sets busy<=0.
  - A single-word packet (last=1 on its first word) never asserts busy.
- While busy=1, changes on sel and mode are ignored. Both are sampled only when busy=0.
- RR pointer: ptr<=c on every transfer with in_last=1, in both modes. The channel that just finished a packet becomes lowest priority. ptr does not change on other cycles.
- Simultaneous drain and load: out_ready=1 with out_valid=1 and a transfer in the same cycle gives back-to-back words with no bubble.
- Locked channel deasserts in_valid mid-packet: no transfer, lock retained, other channels are not served (no timeout).
- Reset mid-packet: lock, pointer and output register are cleared per reset values; the partially sent packet is dropped downstream.
- No internal buffering beyond the single output register. Data are never duplicated or dropped except by reset.

Test Plan:
1. Reset, then mode=0, sel=5, ch5 sends 0xA1 (last=1), out_ready=1 -> cycle+1: out_valid=1, out_data=0xA1, out_last=1, grant=5; in_ready=0x0020 during transfer.
2. mode=1, all 16 channels valid with single-word packets (data=channel index), out_ready=1 -> out_data sequence 0,1,2,...,15,0 on consecutive cycles with no bubbles.
3. mode=1, ch3 sends a 3-word packet (last on word 3) while ch7 is continuously valid -> output ch3 x3 words with busy=1 after word 1 until word 3 transfers; then ch7 is granted.
4. mode=0, sel=2, 4-word packet on ch2; sel changed to 9 after word 2 -> words 3 and 4 still taken from ch2, in_ready[9]=0; the next packet comes from ch9.
5. Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data/out_last/grant stable, in_ready all 0; out_ready=1 -> the held word drains and the next word loads in the same cycle.
6. rst_n=0 for one cycle mid-packet on ch4 -> out_valid=0, busy=0, in_ready=0 that cycle; afterwards mode=1 with ch0 and ch4 valid -> ch0 granted first (ptr=15).
